// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB branch predictor.
//   bp_rec_t      : shadow prediction record carried IF->D->E->M
//   bp_ctr_init   : reset/allocation value of a direction counter (weakly taken)
//   bp_index      : BTB index, pc[idx_bits+1:2]
//   bp_tag        : BTB tag, pc[DW-1:idx_bits+2]
//   bp_sat_step   : saturating increment/decrement of a direction counter
// Package helpers work on fixed maximum widths; callers zero-extend their
// operands and cast the result down to the width they actually use.
package bp_pkg;

    localparam int BP_MAX_DW  = 64;  // widest supported DATA_WIDTH
    localparam int BP_MAX_CTR = 32;  // widest supported CTR_BITS

    typedef struct packed {
        logic                 valid;
        logic                 pred_taken;
        logic [BP_MAX_DW-1:0] pred_target;
        logic                 hit;
    } bp_rec_t;

    function automatic logic [BP_MAX_CTR-1:0] bp_ctr_init(input int unsigned ctr_bits);
        return BP_MAX_CTR'(1) << (ctr_bits - 1);
    endfunction

    function automatic logic [BP_MAX_DW-1:0] bp_index(input logic [BP_MAX_DW-1:0] pc,
                                                      input int unsigned idx_bits);
        return (pc >> 2) & ((BP_MAX_DW'(1) << idx_bits) - BP_MAX_DW'(1));
    endfunction

    function automatic logic [BP_MAX_DW-1:0] bp_tag(input logic [BP_MAX_DW-1:0] pc,
                                                    input int unsigned idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

    function automatic logic [BP_MAX_CTR-1:0] bp_sat_step(input logic [BP_MAX_CTR-1:0] value,
                                                          input logic up,
                                                          input int unsigned bits);
        logic [BP_MAX_CTR-1:0] max_val;
        max_val = BP_MAX_CTR'((64'd1 << bits) - 64'd1);
        if (up)
            return (value >= max_val) ? value : value + BP_MAX_CTR'(1);
        return (value == '0) ? value : value - BP_MAX_CTR'(1);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer storage.
//   clk, rst        : clock, asynchronous active-high reset (valid bits, counters)
//   rd_idx          : combinational lookup index
//   rd_valid/tag/target/ctr_msb : entry contents at rd_idx (pre-write values)
//   wr_en, wr_idx   : resolve-time update strobe and index
//   wr_tag, wr_target, wr_taken : resolved branch information
// The update rule (hit/miss, counter step, allocation) is applied here as a
// read-modify-write of the addressed entry, with the hit recomputed against
// the current contents.
module btb_table
    import bp_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int IDX        = 4,
    parameter int TAG_W      = 26,
    parameter int DATA_WIDTH = 32,
    parameter int CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX-1:0]        rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_target,
    output logic                  rd_ctr_msb,
    input  logic                  wr_en,
    input  logic [IDX-1:0]        wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_target,
    input  logic                  wr_taken
);

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(bp_ctr_init(CTR_BITS));

    logic [ENTRIES-1:0]    valid_reg;
    logic [CTR_BITS-1:0]   ctr_mem    [ENTRIES];
    logic [TAG_W-1:0]      tag_mem    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_mem [ENTRIES];

    logic [ENTRIES-1:0]    wr_sel;
    logic                  wr_hit;
    logic [CTR_BITS-1:0]   ctr_inc;
    logic [CTR_BITS-1:0]   ctr_dec;

    // One-hot write select per entry.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en && (wr_idx == IDX'(gi));
    end

    assign rd_valid   = valid_reg[rd_idx];
    assign rd_tag     = tag_mem[rd_idx];
    assign rd_target  = target_mem[rd_idx];
    assign rd_ctr_msb = ctr_mem[rd_idx][CTR_BITS-1];

    assign wr_hit  = valid_reg[wr_idx] && (tag_mem[wr_idx] == wr_tag);
    assign ctr_inc = CTR_BITS'(bp_sat_step(BP_MAX_CTR'(ctr_mem[wr_idx]), 1'b1, CTR_BITS));
    assign ctr_dec = CTR_BITS'(bp_sat_step(BP_MAX_CTR'(ctr_mem[wr_idx]), 1'b0, CTR_BITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_mem[i] <= CTR_INIT;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr_sel[i]) begin
                    if (wr_taken) begin
                        // Taken: strengthen on hit, otherwise (re)allocate weakly taken.
                        valid_reg[i] <= 1'b1;
                        ctr_mem[i]   <= wr_hit ? ctr_inc : CTR_INIT;
                    end else if (wr_hit) begin
                        ctr_mem[i]   <= ctr_dec;
                    end
                end
            end
        end
    end

    // Tags and targets need no reset: they are only observed behind valid.
    // A taken resolution always (re)writes them, on hit or on allocation.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr_sel[i] && wr_taken) begin
                tag_mem[i]    <= wr_tag;
                target_mem[i] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: BTB lookup in IF, shadow prediction record
// pipeline IF->D->E->M, self-check at MEM, table update and statistics.
//   clk, rst               : clock, asynchronous active-high reset
//   pc_f                   : IF PC (combinational lookup)
//   stall, hold_fd, flush  : pipeline control (freeze / load-use / redirect)
//   is_branch_m, taken_m, target_m, pc_m : resolved MEM-stage instruction
//   pred_taken, pred_target: IF prediction
//   error, correct, new_label : MEM-stage verdict and recovery PC
//   branch_cnt, mispred_cnt   : saturating statistics
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int CNT_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_f,
    input  logic                  stall,
    input  logic                  hold_fd,
    input  logic                  flush,
    input  logic                  is_branch_m,
    input  logic                  taken_m,
    input  logic [DATA_WIDTH-1:0] target_m,
    input  logic [DATA_WIDTH-1:0] pc_m,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    output logic                  error,
    output logic                  correct,
    output logic [DATA_WIDTH-1:0] new_label,
    output logic [CNT_BITS-1:0]   branch_cnt,
    output logic [CNT_BITS-1:0]   mispred_cnt
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    logic [IDX-1:0]        idx_f;
    logic [IDX-1:0]        idx_m;
    logic [TAG_W-1:0]      tag_f;
    logic [TAG_W-1:0]      tag_m;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_target;
    logic                  rd_ctr_msb;
    logic                  hit_f;
    logic                  upd_en;

    bp_rec_t rec_f;
    bp_rec_t rec_d_reg;
    bp_rec_t rec_e_reg;
    bp_rec_t rec_m_reg;

    logic                  res_valid;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] m_pred_target;
    logic [CNT_BITS-1:0]   branch_cnt_reg;
    logic [CNT_BITS-1:0]   mispred_cnt_reg;
    logic                  unused_rec;

    assign idx_f = IDX'(bp_index(BP_MAX_DW'(pc_f), IDX));
    assign tag_f = TAG_W'(bp_tag(BP_MAX_DW'(pc_f), IDX));
    assign idx_m = IDX'(bp_index(BP_MAX_DW'(pc_m), IDX));
    assign tag_m = TAG_W'(bp_tag(BP_MAX_DW'(pc_m), IDX));

    btb_table #(
        .ENTRIES    (ENTRIES),
        .IDX        (IDX),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH),
        .CTR_BITS   (CTR_BITS)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (idx_f),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_target  (rd_target),
        .rd_ctr_msb (rd_ctr_msb),
        .wr_en      (upd_en),
        .wr_idx     (idx_m),
        .wr_tag     (tag_m),
        .wr_target  (target_m),
        .wr_taken   (taken_m)
    );

    // ---------------- IF lookup ----------------
    assign hit_f       = rd_valid && (rd_tag == tag_f);
    assign pred_taken  = hit_f && rd_ctr_msb;
    assign pred_target = pred_taken ? rd_target : pc_f + DATA_WIDTH'(4);

    always_comb begin
        rec_f             = '0;
        rec_f.valid       = 1'b1;
        rec_f.pred_taken  = pred_taken;
        rec_f.pred_target = BP_MAX_DW'(pred_target);
        rec_f.hit         = hit_f;
    end

    // ---------------- record pipeline ----------------
    // flush beats stall; stall freezes everything; hold_fd keeps D and
    // injects a bubble into E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_d_reg <= '0;
            rec_e_reg <= '0;
            rec_m_reg <= '0;
        end else if (flush) begin
            rec_d_reg <= '0;
            rec_e_reg <= '0;
            rec_m_reg <= '0;
        end else if (!stall) begin
            rec_m_reg <= rec_e_reg;
            rec_e_reg <= hold_fd ? '0 : rec_d_reg;
            if (!hold_fd)
                rec_d_reg <= rec_f;
        end
    end

    // ---------------- MEM resolution ----------------
    // The record stays in M while stalled, so the verdict is merely gated
    // and reappears when the stall drops.
    assign res_valid     = rec_m_reg.valid && !stall;
    assign m_pred_target = DATA_WIDTH'(rec_m_reg.pred_target);

    always_comb begin
        mispredict = 1'b0;
        if (is_branch_m)
            mispredict = (rec_m_reg.pred_taken != taken_m) ||
                         (rec_m_reg.pred_taken && (m_pred_target != target_m));
        else
            mispredict = rec_m_reg.pred_taken;  // aliased non-branch
    end

    assign error     = res_valid && mispredict;
    assign correct   = res_valid && !mispredict && rec_m_reg.pred_taken;
    // A non-branch always recovers to the fall-through PC.
    assign new_label = (is_branch_m && taken_m) ? target_m : pc_m + DATA_WIDTH'(4);

    // Update still fires on a flush edge: that is the edge the branch retires on.
    assign upd_en = res_valid && is_branch_m;

    // The record's hit bit is informational; the update recomputes the hit.
    assign unused_rec = ^{rec_m_reg.hit, rec_m_reg.pred_target};

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (upd_en && (branch_cnt_reg != '1))
                branch_cnt_reg <= branch_cnt_reg + CNT_BITS'(1);
            if (error && (mispred_cnt_reg != '1))
                mispred_cnt_reg <= mispred_cnt_reg + CNT_BITS'(1);
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Randomized scoreboard bench for branch_predictor_btb. A reference model
// (BTB as plain arrays, pipeline as three slots) produces the expected
// per-cycle outputs, pushed into a queue; a monitor pops and compares.
module tb_branch_predictor_btb;

    localparam int DW    = 32;
    localparam int ENT   = 16;
    localparam int CTRB  = 2;
    localparam int CNTB  = 3;
    localparam int N_CYC = 3000;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   pc_f;
    logic            stall;
    logic            hold_fd;
    logic            flush;
    logic            is_branch_m;
    logic            taken_m;
    logic [DW-1:0]   target_m;
    logic [DW-1:0]   pc_m;
    logic            pred_taken;
    logic [DW-1:0]   pred_target;
    logic            error;
    logic            correct;
    logic [DW-1:0]   new_label;
    logic [CNTB-1:0] branch_cnt;
    logic [CNTB-1:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor_btb #(
        .DATA_WIDTH (DW),
        .ENTRIES    (ENT),
        .CTR_BITS   (CTRB),
        .CNT_BITS   (CNTB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_f        (pc_f),
        .stall       (stall),
        .hold_fd     (hold_fd),
        .flush       (flush),
        .is_branch_m (is_branch_m),
        .taken_m     (taken_m),
        .target_m    (target_m),
        .pc_m        (pc_m),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .error       (error),
        .correct     (correct),
        .new_label   (new_label),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    // ---------------- program: a small pool of instructions ----------------
    // kind 0: always a branch, 1: never a branch, 2: sometimes a branch.
    // 0x100/0x140/0x200 share index 0, 0x104/0x184 share index 1.
    logic [31:0] pool_pc  [8] = '{32'h100, 32'h140, 32'h104, 32'h108,
                                  32'h200, 32'h10C, 32'h184, 32'h3F0};
    int          pool_kind[8] = '{0, 0, 0, 2, 0, 1, 0, 0};
    logic [31:0] pool_tgt [8] = '{32'h080, 32'h2C0, 32'h400, 32'h500,
                                  32'h600, 32'h000, 32'h090, 32'h3E0};

    // ---------------- reference model ----------------
    bit          m_valid[ENT];
    logic [31:0] m_tag  [ENT];
    logic [31:0] m_tgt  [ENT];
    int          m_ctr  [ENT];
    int          exp_bc;
    int          exp_mc;

    typedef struct {
        bit          v;
        bit          pt;
        logic [31:0] ptgt;
        int          slot;
    } rec_t;
    rec_t pipe[3];  // 0 = D, 1 = E, 2 = M

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        err;
        logic        cor;
        logic [31:0] nl;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 2;
        end
        for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic bit hit_of(input logic [31:0] pc);
        int i;
        i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    endfunction

    function automatic void lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        pt  = hit_of(pc) && (m_ctr[i] >= 2);
        tgt = pt ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void resolve(output bit err, output bit cor, output logic [31:0] nl);
        bit v;
        bit wrong;
        v = pipe[2].v && !stall;
        if (is_branch_m)
            wrong = (pipe[2].pt != taken_m) || (pipe[2].pt && pipe[2].ptgt != target_m);
        else
            wrong = pipe[2].pt;
        err = v && wrong;
        cor = v && !wrong && pipe[2].pt;
        nl  = (is_branch_m && taken_m) ? target_m : pc_m + 32'd4;
    endfunction

    // State change at a clock edge, from the inputs held across it.
    function automatic void model_edge(input int slot_f);
        bit          err;
        bit          cor;
        logic [31:0] nl;
        rec_t        ifr;
        int          i;
        resolve(err, cor, nl);
        lookup(pc_f, ifr.pt, ifr.ptgt);  // lookup sees the pre-update table
        ifr.v    = 1'b1;
        ifr.slot = slot_f;
        if (pipe[2].v && !stall && is_branch_m) begin
            exp_bc = (exp_bc < 7) ? exp_bc + 1 : 7;
            i = idx_of(pc_m);
            if (hit_of(pc_m)) begin
                if (taken_m) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = target_m;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (taken_m) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = pc_m / (4 * ENT);
                m_tgt[i]   = target_m;
                m_ctr[i]   = 2;
            end
        end
        if (err) exp_mc = (exp_mc < 7) ? exp_mc + 1 : 7;
        if (flush) begin
            for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
        end else if (!stall) begin
            pipe[2] = pipe[1];
            if (hold_fd) begin
                pipe[1].v = 1'b0;
            end else begin
                pipe[1] = pipe[0];
                pipe[0] = ifr;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pred_taken",  32'(pred_taken),  32'(e.pt));
                check("pred_target", pred_target,      e.ptgt);
                check("error",       32'(error),       32'(e.err));
                check("correct",     32'(correct),     32'(e.cor));
                check("new_label",   new_label,        e.nl);
                check("branch_cnt",  32'(branch_cnt),  e.bc);
                check("mispred_cnt", 32'(mispred_cnt), e.mc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   slot_f;
        int   s;
        exp_t e;
        bit   pt;
        bit   err;
        bit   cor;
        logic [31:0] ptgt;
        logic [31:0] nl;

        rst = 1'b1; pc_f = '0; stall = 1'b0; hold_fd = 1'b0; flush = 1'b0;
        is_branch_m = 1'b0; taken_m = 1'b0; target_m = '0; pc_m = '0;
        model_reset();
        slot_f = 0;
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            // Reset is asserted mid-cycle and held over one edge.
            rst     = (cyc % 250 == 249);
            stall   = ($urandom_range(99) < 12);
            hold_fd = ($urandom_range(99) < 10);
            flush   = ($urandom_range(99) < 6);
            slot_f  = $urandom_range(7);
            pc_f    = pool_pc[slot_f];
            if (pipe[2].v) begin
                s           = pipe[2].slot;
                pc_m        = pool_pc[s];
                is_branch_m = (pool_kind[s] == 0) || (pool_kind[s] == 2 && $urandom_range(1) == 1);
                taken_m     = is_branch_m && ($urandom_range(99) < 70);
                target_m    = ($urandom_range(7) == 0) ? pc_m + 32'h40 : pool_tgt[s];
            end else begin
                pc_m        = pool_pc[$urandom_range(7)];
                is_branch_m = $urandom_range(1) == 1;
                taken_m     = $urandom_range(1) == 1;
                target_m    = $urandom;
            end
            if (rst) model_reset();

            lookup(pc_f, pt, ptgt);
            resolve(err, cor, nl);
            e.pt = pt; e.ptgt = ptgt; e.err = err; e.cor = cor; e.nl = nl;
            e.bc = 32'(exp_bc); e.mc = 32'(exp_mc);
            exp_q.push_back(e);
            if (pipe[2].v && !stall)
                $display("txn cyc=%0d pc_m=0x%0h br=%0b tk=%0b pred=%0b exp_err=%0b exp_cor=%0b",
                         cyc, pc_m, is_branch_m, taken_m, pipe[2].pt, err, cor);

            @(posedge clk);
            if (!rst) model_edge(slot_f);
            #1;
        end
        rst = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
